// File: rtl/svec_pkg.sv
// Shared definitions for the secret-vector stream buffer: default geometry,
// derived-size helpers and the stream FSM state type.
package svec_pkg;

  localparam int unsigned DEF_COEF_W   = 4;
  localparam int unsigned DEF_WORD_W   = 64;
  localparam int unsigned DEF_N_COEF   = 256;
  localparam int unsigned DEF_NUM_POLY = 3;
  localparam int unsigned DEF_MAX_MAG  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Words per polynomial.
  function automatic int unsigned calc_wpp(input int unsigned n_coef,
                                           input int unsigned coef_w,
                                           input int unsigned word_w);
    return (n_coef * coef_w) / word_w;
  endfunction

  // Index width for a range of 'depth' entries; never narrower than one bit.
  function automatic int unsigned calc_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/svec_skid.sv
// Two-entry valid/ready skid buffer carrying a data word plus its last flag.
// The head entry drives the outputs directly, so they are register outputs and
// hold stable while the consumer stalls.
module svec_skid #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  input  logic              i_out_ready,
  output logic [1:0]        o_occ
);

  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_head_data;
  logic              r_head_last;
  logic [DATA_W-1:0] r_tail_data;
  logic              r_tail_last;
  logic              w_pop;

  assign w_pop       = (r_occ != 2'd0) && i_out_ready;
  assign o_out_valid = (r_occ != 2'd0);
  assign o_out_data  = r_head_data;
  assign o_out_last  = r_head_last;
  assign o_occ       = r_occ;

  // Occupancy and entry update; the producer only pushes when there is room.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_in_valid) begin
            r_head_data <= i_in_data;
            r_head_last <= i_in_last;
            r_occ       <= 2'd1;
          end
        end
        2'd1: begin
          if (i_in_valid && w_pop) begin
            r_head_data <= i_in_data;
            r_head_last <= i_in_last;
          end else if (i_in_valid) begin
            r_tail_data <= i_in_data;
            r_tail_last <= i_in_last;
            r_occ       <= 2'd2;
          end else if (w_pop) begin
            r_occ <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            if (i_in_valid) begin
              r_tail_data <= i_in_data;
              r_tail_last <= i_in_last;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/s_poly_stream_buf.sv
// Multi-polynomial store for the secret vector s. The host loads packed
// sign-magnitude words; a start request streams one polynomial, word 0 first,
// through a two-entry skid buffer to the multiplier.
// Optional feature macro: S_RANGE_CHECK_EN adds a sticky coefficient range
// checker on accepted writes and the o_range_err port.
module s_poly_stream_buf
  import svec_pkg::*;
#(
  parameter int unsigned COEF_W   = DEF_COEF_W,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned N_COEF   = DEF_N_COEF,
  parameter int unsigned NUM_POLY = DEF_NUM_POLY,
`ifdef S_RANGE_CHECK_EN
  parameter int unsigned MAX_MAG  = DEF_MAX_MAG,
`endif
  localparam int unsigned WPP    = calc_wpp(N_COEF, COEF_W, WORD_W),
  localparam int unsigned DEPTH  = NUM_POLY * WPP,
  localparam int unsigned ADDR_W = calc_addr_w(DEPTH),
  localparam int unsigned PSEL_W = calc_addr_w(NUM_POLY)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic              o_wr_reject,
  input  logic              i_start,
  input  logic [PSEL_W-1:0] i_poly_sel,
  output logic              o_start_err,
  output logic              o_busy,
  output logic [WORD_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_done
`ifdef S_RANGE_CHECK_EN
  ,
  output logic              o_range_err
`endif
);

  localparam int unsigned PTR_W = calc_addr_w(WPP);

  logic [WORD_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_d;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_base_d;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_rd_ptr_d;

  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_sel_base;
  logic              w_done_d;

  logic              r_rd_valid;
  logic              r_rd_last;
  logic [WORD_W-1:0] r_rd_data;

  logic              r_wr_reject;
  logic              r_start_err;
  logic              r_done;

  logic              w_start_ok;
  logic              w_wr_ok;
  logic              w_fwd;
  logic              w_skid_valid;
  logic              w_skid_last;
  logic [1:0]        w_occ;
  logic              w_pop;
  logic              w_room;

  assign w_start_ok = i_start && (r_state == IDLE) && (32'(i_poly_sel) < NUM_POLY);
  assign w_wr_ok    = i_wr_en && (r_state == IDLE) && (32'(i_wr_addr) < DEPTH);
  assign w_sel_base = ADDR_W'(32'(i_poly_sel) * WPP);
  assign w_pop      = w_skid_valid && i_out_ready;
  // Room for one more read once this cycle's pop and the in-flight read are counted.
  assign w_room     = ({1'b0, w_occ} + {2'b00, r_rd_valid}) < (3'd2 + {2'b00, w_pop});
  // A write accepted in the same cycle as a read of that word is forwarded.
  assign w_fwd      = w_wr_ok && (i_wr_addr == w_rd_addr);

  assign o_busy      = (r_state != IDLE);
  assign o_out_valid = w_skid_valid;
  assign o_out_last  = w_skid_last && w_skid_valid;
  assign o_wr_reject = r_wr_reject;
  assign o_start_err = r_start_err;
  assign o_done      = r_done;

  // Next-state, read issue and read address selection.
  always_comb begin
    w_state_d    = r_state;
    w_base_d     = r_base;
    w_rd_ptr_d   = r_rd_ptr;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_rd_addr    = r_base + ADDR_W'(r_rd_ptr);
    w_done_d     = 1'b0;
    case (r_state)
      IDLE: begin
        // First read goes out in the start cycle itself to meet the T+2 latency.
        if (w_start_ok) begin
          w_issue    = 1'b1;
          w_rd_addr  = w_sel_base;
          w_base_d   = w_sel_base;
          if (WPP == 1) begin
            w_issue_last = 1'b1;
            w_rd_ptr_d   = '0;
            w_state_d    = DRAIN;
          end else begin
            w_rd_ptr_d = PTR_W'(1);
            w_state_d  = STREAM;
          end
        end
      end
      STREAM: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_rd_ptr == PTR_W'(WPP - 1)) begin
            w_issue_last = 1'b1;
            w_rd_ptr_d   = '0;
            w_state_d    = DRAIN;
          end else begin
            w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_skid_last) begin
          w_done_d  = 1'b1;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // FSM, pointer and status pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_rd_ptr    <= '0;
      r_wr_reject <= 1'b0;
      r_start_err <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_base      <= w_base_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_wr_reject <= i_wr_en && !w_wr_ok;
      r_start_err <= i_start && !w_start_ok;
      r_done      <= w_done_d;
    end
  end

  // Storage array; deliberately not reset so a key survives rst.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Synchronous read port with one cycle of latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_issue;
      r_rd_last  <= w_issue_last;
      if (w_issue) begin
        r_rd_data <= w_fwd ? i_wr_data : r_mem[w_rd_addr];
      end
    end
  end

  svec_skid #(
    .DATA_W (WORD_W)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (r_rd_valid),
    .i_in_data   (r_rd_data),
    .i_in_last   (r_rd_last),
    .o_out_valid (w_skid_valid),
    .o_out_data  (o_out_data),
    .o_out_last  (w_skid_last),
    .i_out_ready (i_out_ready),
    .o_occ       (w_occ)
  );

`ifdef S_RANGE_CHECK_EN
  localparam int unsigned NCPW = WORD_W / COEF_W;

  logic r_range_err;

  assign o_range_err = r_range_err;

  // Flags magnitudes above MAX_MAG and the negative-zero encoding.
  function automatic logic word_bad(input logic [WORD_W-1:0] w);
    logic              bad;
    logic [COEF_W-1:0] c;
    logic [COEF_W-2:0] mag;
    bad = 1'b0;
    for (int k = 0; k < NCPW; k++) begin
      c   = w[k*COEF_W +: COEF_W];
      mag = c[COEF_W-2:0];
      if ((32'(mag) > MAX_MAG) || (c[COEF_W-1] && (mag == '0))) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // Sticky error; the offending write still lands in memory.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_range_err <= 1'b0;
    end else if (w_wr_ok && word_bad(i_wr_data)) begin
      r_range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_s_poly_stream_buf.sv
// Directed bench for s_poly_stream_buf: a scoreboard queue receives the
// expected words when a stream is started and a negedge monitor pops them on
// every handshake, also checking that stalled outputs hold.
module tb_s_poly_stream_buf;

  localparam int WPP   = 16;
  localparam int DEPTH = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_reject;
  logic        start;
  logic [1:0]  poly_sel;
  logic        start_err;
  logic        busy;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;
`ifdef S_RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  logic [63:0] model [DEPTH];
  logic [64:0] sbq [$];
  logic [64:0] sb_exp;
  logic        stall_q = 1'b0;
  logic [63:0] held_d;
  logic        held_l;

  always #5 clk = ~clk;

  s_poly_stream_buf dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_reject (wr_reject),
    .i_start     (start),
    .i_poly_sel  (poly_sel),
    .o_start_err (start_err),
    .o_busy      (busy),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_done      (done)
`ifdef S_RANGE_CHECK_EN
    ,
    .o_range_err (range_err)
`endif
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor and stall-stability checker.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", {64'd0, out_valid}, 65'd1);
        chk("stall_data", {1'b0, out_data}, {1'b0, held_d});
        chk("stall_last", {64'd0, out_last}, {64'd0, held_l});
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL sb_extra: observed word %h expected none", out_data);
        end else begin
          sb_exp = sbq.pop_front();
          chk("sb_word", {out_last, out_data}, sb_exp);
        end
      end
      stall_q = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic logic rdy_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    case (cyc % 4)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // inj: 0 none, 1 start while busy, 2 write while busy, 3 write alongside start.
  task automatic run_stream(input int p, input int mode, input int exp_cyc, input int inj);
    int cyc;
    int hs0;
    if (inj == 3) begin
      wr_en   = 1'b1;
      wr_addr = 6'(p * WPP + 5);
      wr_data = 64'hDEAD_BEEF_0123_4567;
      model[p * WPP + 5] = wr_data;
    end
    poly_sel = 2'(p);
    start    = 1'b1;
    for (int w = 0; w < WPP; w++) sbq.push_back({(w == WPP - 1), model[p * WPP + w]});
    hs0       = hs_cnt;
    cyc       = 0;
    out_ready = rdy_pat(mode, 0);
    while (1) begin
      step();
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      if (inj == 3 && cyc == 1) chk("sim_wr_accept", {64'd0, wr_reject}, 65'd0);
      if (mode == 0 && cyc == 1) chk("lat_valid_t1", {64'd0, out_valid}, 65'd0);
      if (mode == 0 && cyc == 2) chk("lat_valid_t2", {64'd0, out_valid}, 65'd1);
      if (inj == 1 && cyc == 4) chk("busy_start_err", {64'd0, start_err}, 65'd1);
      if (inj == 2 && cyc == 4) chk("busy_wr_reject", {64'd0, wr_reject}, 65'd1);
      if (cyc == 3 && inj == 1) begin
        start    = 1'b1;
        poly_sel = 2'd0;
      end
      if (cyc == 3 && inj == 2) begin
        wr_en   = 1'b1;
        wr_addr = 6'(p * WPP + 2);
        wr_data = ~model[p * WPP + 2];
      end
      out_ready = rdy_pat(mode, cyc);
      if (done) break;
      if (cyc >= 300) begin
        n_chk++;
        n_fail++;
        $error("FAIL done_timeout: observed no done after %0d cycles expected done", cyc);
        break;
      end
    end
    if (exp_cyc != 0) chk("done_latency", 65'(cyc), 65'(exp_cyc));
    chk("handshakes", 65'(hs_cnt - hs0), 65'(WPP));
    chk("sb_drained", 65'(sbq.size()), 65'd0);
    chk("busy_at_done", {64'd0, busy}, 65'd0);
    out_ready = 1'b1;
    step();
    chk("done_pulse_end", {64'd0, done}, 65'd0);
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    poly_sel  = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_last", {64'd0, out_last}, 65'd0);
    chk("rst_done", {64'd0, done}, 65'd0);
    chk("rst_wr_reject", {64'd0, wr_reject}, 65'd0);
    chk("rst_start_err", {64'd0, start_err}, 65'd0);
    chk("rst_data", {1'b0, out_data}, 65'd0);
`ifdef S_RANGE_CHECK_EN
    chk("rst_range_err", {64'd0, range_err}, 65'd0);
`endif
    rst = 1'b0;
    step();

    // Load all polynomials.
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < WPP; w++) begin
        logic [3:0] nib;
        nib = 4'(w);
        model[p * WPP + w] = {16{nib}} ^ 64'(p);
        write_word(p * WPP + w, model[p * WPP + w]);
      end
    end
    chk("load_no_reject", {64'd0, wr_reject}, 65'd0);

    // Full-rate stream, then stalls.
    run_stream(1, 0, 18, 0);
    run_stream(1, 1, 0, 0);

    // Start while busy, then an out-of-range poly_sel.
    run_stream(2, 0, 18, 1);
    poly_sel = 2'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("bad_sel_err", {64'd0, start_err}, 65'd1);
    chk("bad_sel_busy", {64'd0, busy}, 65'd0);
    step();
    chk("bad_sel_pulse", {64'd0, start_err}, 65'd0);

    // Write while busy must not disturb memory; out-of-range address rejected.
    run_stream(0, 0, 18, 2);
    run_stream(0, 0, 18, 0);
    write_word(48, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addr48_reject", {64'd0, wr_reject}, 65'd1);

    // Write and start together in IDLE.
    run_stream(1, 0, 18, 3);

    // Reset in the middle of a stream.
    poly_sel = 2'd0;
    start    = 1'b1;
    for (int w = 0; w < WPP; w++) sbq.push_back({(w == WPP - 1), model[w]});
    step();
    start = 1'b0;
    repeat (8) step();
    chk("mid_word7", {1'b0, out_data}, {1'b0, model[7]});
    rst = 1'b1;
    #1;
    chk("abort_valid", {64'd0, out_valid}, 65'd0);
    chk("abort_busy", {64'd0, busy}, 65'd0);
    chk("abort_last", {64'd0, out_last}, 65'd0);
    chk("abort_data", {1'b0, out_data}, 65'd0);
    chk("abort_done", {64'd0, done}, 65'd0);
    sbq.delete();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_done", {64'd0, done}, 65'd0);

`ifdef S_RANGE_CHECK_EN
    chk("range_clear", {64'd0, range_err}, 65'd0);
    model[47] = 64'hD;
    write_word(47, model[47]);
    chk("range_ok_d", {64'd0, range_err}, 65'd0);
    model[46] = 64'h6;
    write_word(46, model[46]);
    chk("range_mag6", {64'd0, range_err}, 65'd1);
    model[47] = 64'hDDDD;
    write_word(47, model[47]);
    chk("range_sticky", {64'd0, range_err}, 65'd1);
`endif

    run_stream(0, 0, 18, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
